// File: rtl/fx_pkg.sv
// ---- fx_pkg: shared types/constants for the FX dynamics stages (rev 1.0) ----
`default_nettype none

package fx_pkg;

  typedef enum logic [2:0] {
    GATE_CLOSED,
    GATE_ATTACK,
    GATE_OPEN,
    GATE_HOLD,
    GATE_RELEASE
  } gate_state_e;

  // Unity gain for a data_w-bit signed path: 1.0 is 2^(data_w-1)
  function automatic int unsigned unity_gain(input int unsigned data_w);
    return 32'd1 << (data_w - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fx_gate_env.sv
// ---- fx_gate_env: linked-stereo peak detector with slow exponential decay (rev 1.0) ----
`default_nettype none

module fx_gate_env #(
  parameter int DATA_W    = 16,
  parameter int ENV_SHIFT = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sample_en,
  input  logic [1:0][DATA_W-1:0] audio_in,
  output logic [DATA_W-2:0]      env
);

  logic [1:0][DATA_W-2:0] mag;
  logic [DATA_W-2:0]      level;

  for (genvar c = 0; c < 2; c++) begin : g_abs
    logic [DATA_W-1:0] neg;
    assign neg = ~audio_in[c] + 1'b1;
    // Most-negative input has no positive twin; clamp to full-scale positive
    always_comb begin
      if (!audio_in[c][DATA_W-1])
        mag[c] = audio_in[c][DATA_W-2:0];
      else if (audio_in[c][DATA_W-2:0] == '0)
        mag[c] = '1;
      else
        mag[c] = neg[DATA_W-2:0];
    end
  end

  assign level = (mag[0] > mag[1]) ? mag[0] : mag[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      env <= '0;
    else if (sample_en) begin
      if (level > env)
        env <= level;
      else
        env <= env - (env >> ENV_SHIFT);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fx_noise_gate.sv
// ---- fx_noise_gate: stereo noise gate with clickless gain FSM (rev 1.0) ----
// FX_GATE_METER_EN adds gate_open / env_level meter outputs.
`default_nettype none

module fx_noise_gate
  import fx_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int PARAM_W     = 7,
  parameter int ATTACK_STEP = 1024,
  parameter int HOLD_SHIFT  = 6,
  parameter int ENV_SHIFT   = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sample_en,
  input  logic [1:0][DATA_W-1:0] audio_in,
  input  logic [PARAM_W-1:0]     fx_threshold,
  input  logic [PARAM_W-1:0]     fx_hold,
  input  logic [PARAM_W-1:0]     fx_release,
  output logic [1:0][DATA_W-1:0] audio_out
`ifdef FX_GATE_METER_EN
  ,
  output logic                   gate_open,
  output logic [DATA_W-2:0]      env_level
`endif
);

  localparam int HOLD_W = PARAM_W + HOLD_SHIFT;
  localparam logic [DATA_W-1:0] UNITY      = DATA_W'(unity_gain(DATA_W));
  localparam logic [DATA_W-1:0] ATTACK_INC = DATA_W'(ATTACK_STEP);

  gate_state_e         state, nxt_state;
  logic [DATA_W-1:0]   gain, nxt_gain;
  logic [HOLD_W-1:0]   hold_cnt, nxt_hold;
  logic [DATA_W-2:0]   env, thr, thr_close;
  logic [DATA_W-1:0]   rel_step;
  logic [DATA_W:0]     attack_sum;
  logic [HOLD_W-1:0]   hold_load;
  logic [1:0][DATA_W-1:0] scaled;

  fx_gate_env #(
    .DATA_W    (DATA_W),
    .ENV_SHIFT (ENV_SHIFT)
  ) u_env (
    .clk       (clk),
    .reset_n   (reset_n),
    .sample_en (sample_en),
    .audio_in  (audio_in),
    .env       (env)
  );

  assign thr        = {fx_threshold, {(DATA_W-1-PARAM_W){1'b0}}};
  assign thr_close  = thr - (thr >> 3);
  assign rel_step   = DATA_W'(fx_release) + 1'b1;
  assign attack_sum = {1'b0, gain} + {1'b0, ATTACK_INC};
  assign hold_load  = {fx_hold, {HOLD_SHIFT{1'b0}}};

  // env here is the pre-update value, so decisions lag the detector by one sample
  always_comb begin
    nxt_state = state;
    nxt_gain  = gain;
    nxt_hold  = hold_cnt;
    case (state)
      GATE_CLOSED: begin
        nxt_gain = '0;
        if (env > thr) nxt_state = GATE_ATTACK;
      end
      GATE_ATTACK: begin
        if (attack_sum >= {1'b0, UNITY}) begin
          nxt_gain  = UNITY;
          nxt_state = GATE_OPEN;
        end else begin
          nxt_gain = attack_sum[DATA_W-1:0];
        end
      end
      GATE_OPEN: begin
        nxt_gain = UNITY;
        if (env < thr_close) begin
          nxt_state = GATE_HOLD;
          nxt_hold  = hold_load;
        end
      end
      GATE_HOLD: begin
        nxt_gain = UNITY;
        if (env > thr)          nxt_state = GATE_OPEN;
        else if (hold_cnt == '0) nxt_state = GATE_RELEASE;
        else                    nxt_hold  = hold_cnt - 1'b1;
      end
      GATE_RELEASE: begin
        if (env > thr) begin
          nxt_state = GATE_ATTACK;
        end else if (gain <= rel_step) begin
          nxt_gain  = '0;
          nxt_state = GATE_CLOSED;
        end else begin
          nxt_gain = gain - rel_step;
        end
      end
      default: begin
        nxt_state = GATE_CLOSED;
        nxt_gain  = '0;
      end
    endcase
  end

  // Q1.(DATA_W-1) gain multiply; gain <= unity so the result always fits DATA_W
  for (genvar c = 0; c < 2; c++) begin : g_mul
    logic signed [2*DATA_W:0] prod;
    logic                     unused_prod;
    assign prod        = $signed(audio_in[c]) * $signed({1'b0, gain});
    assign scaled[c]   = prod[2*DATA_W-2:DATA_W-1];
    assign unused_prod = ^{prod[2*DATA_W:2*DATA_W-1], prod[DATA_W-2:0]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= GATE_CLOSED;
      gain      <= '0;
      hold_cnt  <= '0;
      audio_out <= '0;
    end else if (sample_en) begin
      state     <= nxt_state;
      gain      <= nxt_gain;
      hold_cnt  <= nxt_hold;
      audio_out <= scaled;
    end
  end

`ifdef FX_GATE_METER_EN
  assign gate_open = (state != GATE_CLOSED);
  assign env_level = env;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fx_noise_gate.sv
// ---- tb_fx_noise_gate: randomized scoreboard bench for fx_noise_gate (rev 1.0) ----
`default_nettype none

module tb_fx_noise_gate;

  localparam int S_CLOSED  = 0;
  localparam int S_ATTACK  = 1;
  localparam int S_OPEN    = 2;
  localparam int S_HOLD    = 3;
  localparam int S_RELEASE = 4;
  localparam int UNITY     = 32768;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              sample_en = 1'b0;
  logic [1:0][15:0]  audio_in = '0;
  logic [6:0]        fx_threshold = 7'd16;
  logic [6:0]        fx_hold = 7'd1;
  logic [6:0]        fx_release = 7'd127;
  logic [1:0][15:0]  audio_out;
`ifdef FX_GATE_METER_EN
  logic              gate_open;
  logic [14:0]       env_level;
`endif

  fx_noise_gate dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_en    (sample_en),
    .audio_in     (audio_in),
    .fx_threshold (fx_threshold),
    .fx_hold      (fx_hold),
    .fx_release   (fx_release),
    .audio_out    (audio_out)
`ifdef FX_GATE_METER_EN
    ,
    .gate_open    (gate_open),
    .env_level    (env_level)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int l; int r; } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Reference model: plain integer arithmetic on the gate rules
  int m_env = 0, m_gain = 0, m_hold = 0, m_st = S_CLOSED;

  function automatic int mag(input int x);
    int a;
    a = (x < 0) ? -x : x;
    return (a > 32767) ? 32767 : a;
  endfunction

  task automatic model_reset();
    m_env = 0; m_gain = 0; m_hold = 0; m_st = S_CLOSED;
  endtask

  task automatic model_sample(input int l, input int r);
    exp_t e;
    int thr, thc, rel, lvl;
    e.l = int'((longint'(l) * longint'(m_gain)) >>> 15);
    e.r = int'((longint'(r) * longint'(m_gain)) >>> 15);
    q.push_back(e);
    thr = int'(fx_threshold) * 256;
    thc = thr - thr / 8;
    rel = int'(fx_release) + 1;
    case (m_st)
      S_CLOSED: begin
        m_gain = 0;
        if (m_env > thr) m_st = S_ATTACK;
      end
      S_ATTACK: begin
        m_gain = m_gain + 1024;
        if (m_gain >= UNITY) begin m_gain = UNITY; m_st = S_OPEN; end
      end
      S_OPEN: begin
        m_gain = UNITY;
        if (m_env < thc) begin m_st = S_HOLD; m_hold = int'(fx_hold) * 64; end
      end
      S_HOLD: begin
        m_gain = UNITY;
        if (m_env > thr) m_st = S_OPEN;
        else if (m_hold == 0) m_st = S_RELEASE;
        else m_hold = m_hold - 1;
      end
      default: begin
        if (m_env > thr) m_st = S_ATTACK;
        else if (m_gain <= rel) begin m_gain = 0; m_st = S_CLOSED; end
        else m_gain = m_gain - rel;
      end
    endcase
    lvl = (mag(l) > mag(r)) ? mag(l) : mag(r);
    if (lvl > m_env) m_env = lvl;
    else m_env = m_env - m_env / 1024;
  endtask

  task automatic issue(input int l, input int r);
    @(negedge clk);
    audio_in[0] = 16'(l);
    audio_in[1] = 16'(r);
    sample_en   = 1'b1;
    model_sample(l, r);
    @(negedge clk);
    sample_en = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  function automatic int noise(input int a);
    return int'($urandom_range(0, 2 * a)) - a;
  endfunction

  // Monitor: every accepted sample yields one registered output
  always @(posedge clk) begin
    if (sample_en && reset_n) begin
      exp_t e;
      int al, ar;
      #1;
      al = int'($signed(audio_out[0]));
      ar = int'($signed(audio_out[1]));
      tests = tests + 1;
      if (q.size() == 0) begin
        fails = fails + 1;
        $display("FAIL sample_out: unexpected output L=%0d R=%0d, none expected", al, ar);
      end else begin
        e = q.pop_front();
        if (al != e.l || ar != e.r) begin
          fails = fails + 1;
          $display("FAIL sample_out: got L=%0d R=%0d, expected L=%0d R=%0d", al, ar, e.l, e.r);
        end
      end
    end
  end

  task automatic check_zero(input string name);
    tests = tests + 1;
    if (audio_out !== '0) begin
      fails = fails + 1;
      $display("FAIL %s: audio_out=%h, expected 0", name, audio_out);
    end
  endtask

  task automatic run_until_closed(input string name);
    int n;
    n = 0;
    while (m_st != S_CLOSED && n < 5000) begin
      issue(noise(800), noise(800));
      n++;
    end
    tests = tests + 1;
    if (m_st != S_CLOSED) begin
      fails = fails + 1;
      $display("FAIL %s: gate still active after %0d samples, expected closed", name, n);
    end
  endtask

  initial begin
    int n, a;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    reset_n = 1'b1;

    // Silence never opens the gate
    repeat (40) issue(0, 0);

    // Step above threshold: attack ramp then unity passthrough
    repeat (50) issue(16000, 16000);

    // Fall back through hold and a fast release to closed
    run_until_closed("release_to_closed");

    // Re-trigger halfway down the release ramp
    repeat (45) issue(16000, -16000);
    n = 0;
    while (!(m_st == S_RELEASE && m_gain <= UNITY / 2) && n < 5000) begin
      issue(noise(800), noise(800));
      n++;
    end
    tests = tests + 1;
    if (!(m_st == S_RELEASE && m_gain <= UNITY / 2)) begin
      fails = fails + 1;
      $display("FAIL retrigger_setup: release midpoint not reached after %0d samples", n);
    end
    repeat (30) issue(20000, 20000);

    // Full-scale negative input with gate open
    repeat (8) issue(-32768, -32768);
    repeat (4) issue(-32768, 1234);

    // Async reset mid-attack
    fx_threshold = 7'd16;
    run_until_closed("close_before_reset");
    repeat (5) issue(16000, 16000);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_zero("async_reset");
    q.delete();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check_zero("idle_after_reset");
    repeat (4) issue(16000, 16000);

    // Randomized bursts with threshold/hold/release changes
    for (int i = 0; i < 900; i++) begin
      if (i % 60 == 0) begin
        fx_threshold = 7'($urandom_range(0, 60));
        fx_hold      = 7'($urandom_range(0, 3));
        fx_release   = 7'($urandom_range(0, 127));
        case ($urandom_range(0, 3))
          0: a = 0;
          1: a = 600;
          2: a = 9000;
          default: a = 32767;
        endcase
      end
      if (a == 32767 && $urandom_range(0, 15) == 0) issue(-32768, noise(a));
      else issue(noise(a), noise(a));
    end

    repeat (4) @(negedge clk);
    tests = tests + 1;
    if (q.size() != 0) begin
      fails = fails + 1;
      $display("FAIL scoreboard_drain: %0d outputs outstanding, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
